// File: rtl/mips_ctrl_pkg.sv
// mips_ctrl_pkg: opcode/funct codes, state encodings, ALU and mux encodings, per-state control decode
package mips_ctrl_pkg;
  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] F_ADD = 6'b100000;
  localparam logic [5:0] F_SUB = 6'b100010;
  localparam logic [5:0] F_SLT = 6'b101010;
  localparam logic [5:0] F_MUL = 6'b011100;
  localparam logic [5:0] F_AND = 6'b100100;
  localparam logic [5:0] F_OR  = 6'b100101;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b100;
  localparam logic [2:0] ALU_SLT = 3'b110;
  localparam logic [2:0] ALU_MUL = 3'b101;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] SRCB_B    = 2'b00;
  localparam logic [1:0] SRCB_4    = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;
  localparam logic [1:0] SRCB_IMM2 = 2'b11;
  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;
  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWR, S_EXECUTE,
    S_ALUWB, S_BRANCH, S_ADDIEX, S_ADDIWB, S_JUMP, S_TRAP
  } state_t;
  typedef struct packed {
    logic iord, mem_write, pc_write, branch, reg_dst, mem_to_reg, reg_write, alu_src_a, instr_done, alu_en;
    logic [1:0] alu_src_b, pc_src, alu_op;
  } ctrl_t;
  // Pure Moore outputs of a state; MemReady/Opcode-dependent strobes are added in the top.
  // alu_en marks states that actually use the ALU, so ALUControl reads 0 elsewhere.
  function automatic ctrl_t decode(state_t s);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH:   begin c.alu_src_b = SRCB_4; c.pc_src = PC_ALU; c.alu_en = 1'b1; end
      S_DECODE:  begin c.alu_src_b = SRCB_IMM2; c.alu_en = 1'b1; end
      S_MEMADR:  begin c.alu_src_a = 1'b1; c.alu_src_b = SRCB_IMM; c.alu_en = 1'b1; end
      S_MEMREAD: c.iord = 1'b1;
      S_MEMWB:   begin c.mem_to_reg = 1'b1; c.reg_write = 1'b1; c.instr_done = 1'b1; end
      S_MEMWR:   begin c.iord = 1'b1; c.mem_write = 1'b1; end
      S_EXECUTE: begin c.alu_src_a = 1'b1; c.alu_src_b = SRCB_B; c.alu_op = ALUOP_FUNCT; c.alu_en = 1'b1; end
      S_ALUWB:   begin c.reg_dst = 1'b1; c.reg_write = 1'b1; c.instr_done = 1'b1; end
      S_BRANCH:  begin c.alu_src_a = 1'b1; c.alu_op = ALUOP_SUB; c.pc_src = PC_ALUOUT; c.branch = 1'b1; c.instr_done = 1'b1; c.alu_en = 1'b1; end
      S_ADDIEX:  begin c.alu_src_a = 1'b1; c.alu_src_b = SRCB_IMM; c.alu_en = 1'b1; end
      S_ADDIWB:  begin c.reg_write = 1'b1; c.instr_done = 1'b1; end
      S_JUMP:    begin c.pc_src = PC_JUMP; c.pc_write = 1'b1; c.instr_done = 1'b1; end
      default:   c = '0;
    endcase
    return c;
  endfunction
endpackage

// File: rtl/alu_decoder.sv
// alu_decoder: ALUOp + Funct -> ALUControl (ports: alu_op, funct in; alu_control out)
module alu_decoder
  import mips_ctrl_pkg::*;
#(
  parameter int FUNCT_W   = 6,
  parameter int ALUCTRL_W = 3
) (
  input  logic [1:0]           alu_op,
  input  logic [FUNCT_W-1:0]   funct,
  output logic [ALUCTRL_W-1:0] alu_control
);
  logic [ALUCTRL_W-1:0] by_funct;
  always_comb begin
    by_funct = ALU_ADD;
    case (funct)
      F_ADD:   by_funct = ALU_ADD;
      F_SUB:   by_funct = ALU_SUB;
      F_SLT:   by_funct = ALU_SLT;
      F_MUL:   by_funct = ALU_MUL;
      F_AND:   by_funct = ALU_AND;
      F_OR:    by_funct = ALU_OR;
      default: by_funct = ALU_ADD;
    endcase
  end
  assign alu_control = alu_op == ALUOP_SUB ? ALU_SUB : alu_op == ALUOP_FUNCT ? by_funct : ALU_ADD;
endmodule

// File: rtl/multicycle_control_unit.sv
// multicycle_control_unit: Moore FSM controller for the multicycle MIPS datapath
// Ports: CLK, RST (async active-high); Opcode/Funct from IR; MemReady memory ack;
//   datapath strobes/selects, ALUControl, InstrDone pulse, State (debug), Illegal (sticky).
// Option: define MCU_ILLEGAL_TRAP_EN to trap unknown opcodes in TRAP; otherwise they retire as NOPs.
module multicycle_control_unit
  import mips_ctrl_pkg::*;
#(
  parameter int OP_W      = 6,
  parameter int FUNCT_W   = 6,
  parameter int ALUCTRL_W = 3,
  parameter int STATE_W   = 4
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [OP_W-1:0]      Opcode,
  input  logic [FUNCT_W-1:0]   Funct,
  input  logic                 MemReady,
  output logic                 IorD,
  output logic                 MemWrite,
  output logic                 IRWrite,
  output logic                 PCWrite,
  output logic                 Branch,
  output logic                 RegDst,
  output logic                 MemtoReg,
  output logic                 RegWrite,
  output logic                 ALUSrcA,
  output logic [1:0]           ALUSrcB,
  output logic [1:0]           PCSrc,
  output logic [ALUCTRL_W-1:0] ALUControl,
  output logic                 InstrDone,
  output logic [STATE_W-1:0]   State,
  output logic                 Illegal
);
  state_t state, nxt;
  ctrl_t c;
  logic [ALUCTRL_W-1:0] alu_ctrl;
  logic live, known, fetch_ack, nop_done;
  assign known = Opcode inside {OP_R, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J};
`ifdef MCU_ILLEGAL_TRAP_EN
  localparam state_t S_BAD = S_TRAP;
  assign nop_done = 1'b0;
  assign Illegal = state == S_TRAP;
`else
  localparam state_t S_BAD = S_FETCH;
  assign nop_done = state == S_DECODE && !known;
  assign Illegal = 1'b0;
`endif
  always_comb begin
    nxt = S_FETCH;
    case (state)
      S_FETCH:   nxt = MemReady ? S_DECODE : S_FETCH;
      S_DECODE:  nxt = (Opcode == OP_LW || Opcode == OP_SW) ? S_MEMADR :
                       Opcode == OP_R    ? S_EXECUTE :
                       Opcode == OP_BEQ  ? S_BRANCH :
                       Opcode == OP_ADDI ? S_ADDIEX :
                       Opcode == OP_J    ? S_JUMP : S_BAD;
      S_MEMADR:  nxt = Opcode == OP_LW ? S_MEMREAD : S_MEMWR;
      S_MEMREAD: nxt = MemReady ? S_MEMWB : S_MEMREAD;
      S_MEMWR:   nxt = MemReady ? S_FETCH : S_MEMWR;
      S_EXECUTE: nxt = S_ALUWB;
      S_ADDIEX:  nxt = S_ADDIWB;
      S_TRAP:    nxt = S_BAD;
      default:   nxt = S_FETCH;
    endcase
  end
  // Control word is registered alongside the state, so it always equals decode(state).
  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      state <= S_FETCH;
      c <= decode(S_FETCH);
    end else begin
      state <= nxt;
      c <= decode(nxt);
    end
  alu_decoder #(.FUNCT_W(FUNCT_W), .ALUCTRL_W(ALUCTRL_W)) u_alu_dec (
    .alu_op(c.alu_op),
    .funct(Funct),
    .alu_control(alu_ctrl)
  );
  // RST blanks every output immediately, including the MemReady-gated fetch strobes.
  assign live = ~RST;
  assign fetch_ack = live && state == S_FETCH && MemReady;
  assign IorD = live & c.iord;
  assign MemWrite = live & c.mem_write;
  assign IRWrite = fetch_ack;
  assign PCWrite = (live & c.pc_write) | fetch_ack;
  assign Branch = live & c.branch;
  assign RegDst = live & c.reg_dst;
  assign MemtoReg = live & c.mem_to_reg;
  assign RegWrite = live & c.reg_write;
  assign ALUSrcA = live & c.alu_src_a;
  assign ALUSrcB = live ? c.alu_src_b : 2'b00;
  assign PCSrc = live ? c.pc_src : 2'b00;
  assign ALUControl = (live && c.alu_en) ? alu_ctrl : '0;
  assign InstrDone = live & (c.instr_done | (state == S_MEMWR && MemReady) | nop_done);
  assign State = STATE_W'(state);
endmodule

// File: tb/tb_multicycle_control_unit.sv
// tb_multicycle_control_unit: scoreboard bench for the multicycle controller
module tb_multicycle_control_unit;
  import mips_ctrl_pkg::*;
  typedef struct packed {
    logic [3:0] st;
    logic iord, mw, irw, pcw, br, rd, m2r, rw, asa;
    logic [1:0] asb, pcs;
    logic [2:0] aluc;
    logic done, ill;
  } ov_t;
  typedef struct packed {logic mr; logic [5:0] op, fn;} in_t;
  logic clk = 1'b0, rst = 1'b1, mem_ready = 1'b1;
  logic [5:0] opcode = '0, funct = '0;
  logic iord, mem_write, ir_write, pc_write, branch, reg_dst, mem_to_reg, reg_write, alu_src_a, instr_done, illegal;
  logic [1:0] alu_src_b, pc_src;
  logic [2:0] alu_control;
  logic [3:0] state;
  ov_t o;
  ov_t exp_q[$], msk_q[$];
  in_t in_q[$];
  logic [5:0] op_s, fn_s;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  multicycle_control_unit dut (
    .CLK(clk), .RST(rst), .Opcode(opcode), .Funct(funct), .MemReady(mem_ready),
    .IorD(iord), .MemWrite(mem_write), .IRWrite(ir_write), .PCWrite(pc_write), .Branch(branch),
    .RegDst(reg_dst), .MemtoReg(mem_to_reg), .RegWrite(reg_write), .ALUSrcA(alu_src_a),
    .ALUSrcB(alu_src_b), .PCSrc(pc_src), .ALUControl(alu_control), .InstrDone(instr_done),
    .State(state), .Illegal(illegal)
  );
  assign o = {state, iord, mem_write, ir_write, pc_write, branch, reg_dst, mem_to_reg, reg_write,
              alu_src_a, alu_src_b, pc_src, alu_control, instr_done, illegal};
  function automatic ov_t so(state_t s);
    ov_t e;
    e = '0;
    e.st = s;
    case (s)
      S_FETCH:   begin e.asb = 2'b01; e.aluc = 3'b010; end
      S_DECODE:  begin e.asb = 2'b11; e.aluc = 3'b010; end
      S_MEMADR:  begin e.asa = 1'b1; e.asb = 2'b10; e.aluc = 3'b010; end
      S_MEMREAD: e.iord = 1'b1;
      S_MEMWB:   begin e.m2r = 1'b1; e.rw = 1'b1; e.done = 1'b1; end
      S_MEMWR:   begin e.iord = 1'b1; e.mw = 1'b1; end
      S_EXECUTE: begin e.asa = 1'b1; e.aluc = 3'b010; end
      S_ALUWB:   begin e.rd = 1'b1; e.rw = 1'b1; e.done = 1'b1; end
      S_BRANCH:  begin e.asa = 1'b1; e.aluc = 3'b100; e.pcs = 2'b01; e.br = 1'b1; e.done = 1'b1; end
      S_ADDIEX:  begin e.asa = 1'b1; e.asb = 2'b10; e.aluc = 3'b010; end
      S_ADDIWB:  begin e.rw = 1'b1; e.done = 1'b1; end
      S_JUMP:    begin e.pcs = 2'b10; e.pcw = 1'b1; e.done = 1'b1; end
      S_TRAP:    e.ill = 1'b1;
      default:   e = '0;
    endcase
    return e;
  endfunction
  // ALUControl is only meaningful in states that drive an ALUOp.
  task automatic push(input ov_t e, input logic mr);
    ov_t m;
    m = '1;
    if (!(e.st inside {S_FETCH, S_DECODE, S_MEMADR, S_EXECUTE, S_BRANCH, S_ADDIEX})) m.aluc = '0;
    exp_q.push_back(e);
    msk_q.push_back(m);
    in_q.push_back({mr, op_s, fn_s});
  endtask
  task automatic fetch(input logic mr);
    ov_t e;
    e = so(S_FETCH);
    e.irw = mr;
    e.pcw = mr;
    push(e, mr);
  endtask
  task automatic exec_r(input logic [5:0] fn, input logic [2:0] aluc);
    ov_t e;
    fn_s = fn;
    op_s = OP_R;
    fetch(1'b1);
    push(so(S_DECODE), 1'b1);
    e = so(S_EXECUTE);
    e.aluc = aluc;
    push(e, 1'b1);
    push(so(S_ALUWB), 1'b1);
  endtask
  task automatic test_reset();
    @(negedge clk);
    checks++;
    if (o !== '0) begin errors++; $display("FAIL reset_hold: got %h want 0", o); end
    @(negedge clk);
    checks++;
    if (o !== '0) begin errors++; $display("FAIL reset_hold2: got %h want 0", o); end
    @(posedge clk);
    #1 rst = 1'b0;
  endtask
  task automatic test_lw();
    op_s = OP_LW;
    fn_s = '0;
    fetch(1'b1);
    push(so(S_DECODE), 1'b1);
    push(so(S_MEMADR), 1'b1);
    push(so(S_MEMREAD), 1'b1);
    push(so(S_MEMWB), 1'b1);
    while (exp_q.size() > 0) begin
      ov_t e, m;
      in_t i;
      i = in_q.pop_front(); e = exp_q.pop_front(); m = msk_q.pop_front();
      mem_ready = i.mr; opcode = i.op; funct = i.fn;
      @(negedge clk);
      checks++;
      if ((o & m) !== (e & m)) begin errors++; $display("FAIL lw: got %h want %h", o, e); end
      @(posedge clk);
      #1;
    end
  endtask
  task automatic test_sw_stall();
    ov_t e;
    op_s = OP_SW;
    fn_s = '0;
    fetch(1'b1);
    push(so(S_DECODE), 1'b0);
    push(so(S_MEMADR), 1'b0);
    repeat (3) push(so(S_MEMWR), 1'b0);
    e = so(S_MEMWR);
    e.done = 1'b1;
    push(e, 1'b1);
    while (exp_q.size() > 0) begin
      ov_t x, m;
      in_t i;
      i = in_q.pop_front(); x = exp_q.pop_front(); m = msk_q.pop_front();
      mem_ready = i.mr; opcode = i.op; funct = i.fn;
      @(negedge clk);
      checks++;
      if ((o & m) !== (x & m)) begin errors++; $display("FAIL sw: got %h want %h", o, x); end
      @(posedge clk);
      #1;
    end
  endtask
  task automatic test_rtype();
    op_s = OP_R;
    fn_s = F_SLT;
    fetch(1'b0);
    exec_r(F_SLT, 3'b110);
    exec_r(6'b111111, 3'b010);
    while (exp_q.size() > 0) begin
      ov_t e, m;
      in_t i;
      i = in_q.pop_front(); e = exp_q.pop_front(); m = msk_q.pop_front();
      mem_ready = i.mr; opcode = i.op; funct = i.fn;
      @(negedge clk);
      checks++;
      if ((o & m) !== (e & m)) begin errors++; $display("FAIL rtype: got %h want %h", o, e); end
      @(posedge clk);
      #1;
    end
  endtask
  task automatic test_beq_jump();
    op_s = OP_BEQ;
    fn_s = '0;
    fetch(1'b1);
    push(so(S_DECODE), 1'b1);
    push(so(S_BRANCH), 1'b0);
    op_s = OP_J;
    fetch(1'b1);
    push(so(S_DECODE), 1'b0);
    push(so(S_JUMP), 1'b1);
    while (exp_q.size() > 0) begin
      ov_t e, m;
      in_t i;
      i = in_q.pop_front(); e = exp_q.pop_front(); m = msk_q.pop_front();
      mem_ready = i.mr; opcode = i.op; funct = i.fn;
      @(negedge clk);
      checks++;
      if ((o & m) !== (e & m)) begin errors++; $display("FAIL beq_j: got %h want %h", o, e); end
      @(posedge clk);
      #1;
    end
  endtask
  task automatic test_back_to_back();
    logic [5:0] fns[5] = '{F_ADD, F_SUB, F_AND, F_OR, F_MUL};
    logic [2:0] alus[5] = '{3'b010, 3'b100, 3'b000, 3'b001, 3'b101};
    op_s = OP_ADDI;
    fn_s = 6'b101010;
    fetch(1'b1);
    push(so(S_DECODE), 1'b1);
    push(so(S_ADDIEX), 1'b1);
    push(so(S_ADDIWB), 1'b1);
    for (int k = 0; k < 5; k++) exec_r(fns[k], alus[k]);
    while (exp_q.size() > 0) begin
      ov_t e, m;
      in_t i;
      i = in_q.pop_front(); e = exp_q.pop_front(); m = msk_q.pop_front();
      mem_ready = i.mr; opcode = i.op; funct = i.fn;
      @(negedge clk);
      checks++;
      if ((o & m) !== (e & m)) begin errors++; $display("FAIL b2b: got %h want %h", o, e); end
      @(posedge clk);
      #1;
    end
  endtask
  task automatic test_illegal();
    ov_t e;
    op_s = 6'b111111;
    fn_s = '0;
    fetch(1'b1);
    e = so(S_DECODE);
`ifdef MCU_ILLEGAL_TRAP_EN
    push(e, 1'b1);
    repeat (3) push(so(S_TRAP), 1'b1);
`else
    e.done = 1'b1;
    push(e, 1'b1);
    fetch(1'b0);
`endif
    while (exp_q.size() > 0) begin
      ov_t x, m;
      in_t i;
      i = in_q.pop_front(); x = exp_q.pop_front(); m = msk_q.pop_front();
      mem_ready = i.mr; opcode = i.op; funct = i.fn;
      @(negedge clk);
      checks++;
      if ((o & m) !== (x & m)) begin errors++; $display("FAIL illegal: got %h want %h", o, x); end
      @(posedge clk);
      #1;
    end
`ifdef MCU_ILLEGAL_TRAP_EN
    rst = 1'b1;
    #1;
    checks++;
    if (o !== '0) begin errors++; $display("FAIL trap_clear: got %h want 0", o); end
    @(posedge clk);
    #1 rst = 1'b0;
`endif
  endtask
  task automatic test_reset_mid();
    op_s = OP_LW;
    fn_s = '0;
    fetch(1'b1);
    push(so(S_DECODE), 1'b1);
    push(so(S_MEMADR), 1'b1);
    push(so(S_MEMREAD), 1'b0);
    push(so(S_MEMREAD), 1'b0);
    while (exp_q.size() > 0) begin
      ov_t e, m;
      in_t i;
      i = in_q.pop_front(); e = exp_q.pop_front(); m = msk_q.pop_front();
      mem_ready = i.mr; opcode = i.op; funct = i.fn;
      @(negedge clk);
      checks++;
      if ((o & m) !== (e & m)) begin errors++; $display("FAIL pre_rst: got %h want %h", o, e); end
      @(posedge clk);
      #1;
    end
    rst = 1'b1;
    mem_ready = 1'b1;
    #1;
    checks++;
    if (o !== '0) begin errors++; $display("FAIL rst_async: got %h want 0", o); end
    @(negedge clk);
    checks++;
    if (o !== '0) begin errors++; $display("FAIL rst_mid: got %h want 0", o); end
    @(posedge clk);
    #1 rst = 1'b0;
    fetch(1'b1);
    push(so(S_DECODE), 1'b1);
    push(so(S_MEMADR), 1'b1);
    push(so(S_MEMREAD), 1'b1);
    push(so(S_MEMWB), 1'b1);
    while (exp_q.size() > 0) begin
      ov_t e, m;
      in_t i;
      i = in_q.pop_front(); e = exp_q.pop_front(); m = msk_q.pop_front();
      mem_ready = i.mr; opcode = i.op; funct = i.fn;
      @(negedge clk);
      checks++;
      if ((o & m) !== (e & m)) begin errors++; $display("FAIL post_rst: got %h want %h", o, e); end
      @(posedge clk);
      #1;
    end
  endtask
  initial begin
    test_reset();
    test_lw();
    test_sw_stall();
    test_rtype();
    test_beq_jump();
    test_back_to_back();
    test_illegal();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
